// File: rtl/nvram_pkg.sv
// ============================================================================
// Module  : nvram_pkg
// Brief   : Shared FSM encoding, default file index and pad constant for the
//           CMOS upload/restore controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nvram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_READY  = 3'd2,
        ST_READ   = 3'd3,
        ST_WACK   = 3'd4
    } nv_state_e;

    localparam int         c_NV_INDEX_DEFAULT = 4;
    localparam logic [7:0] c_PAD_BYTE         = 8'hFF;

    // Counter width able to hold the larger of the two load values.
    function automatic int nv_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nvram_settle_cnt.sv
// ============================================================================
// Module  : nvram_settle_cnt
// Brief   : Loadable down-counter; done is high whenever the count is zero.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nvram_settle_cnt #(
    parameter int WIDTH = 5
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/nvram_upload_ctrl.sv
// ============================================================================
// Module  : nvram_upload_ctrl
// Brief   : Bridges the hps_io ioctl file channel to the CMOS RAM port for
//           save/restore; optional dirty tracking under NVRAM_DIRTY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nvram_upload_ctrl
    import nvram_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 4,
    parameter int NV_INDEX     = c_NV_INDEX_DEFAULT,
    parameter int RD_LATENCY   = 2,
    parameter int PAUSE_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_download,
    input  logic [15:0]       ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic              ioctl_rd,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              cpu_pause,
    output logic [ADDR_W-1:0] nv_addr,
    input  logic [DATA_W-1:0] nv_rdata,
    output logic [DATA_W-1:0] nv_wdata,
    output logic              nv_we,
    input  logic              game_nv_we,
    output logic              nv_dirty
);

    localparam int CNT_W = nv_cnt_width(PAUSE_CYCLES, RD_LATENCY);

    localparam logic [2:0] c_ST_IDLE   = ST_IDLE;
    localparam logic [2:0] c_ST_SETTLE = ST_SETTLE;
    localparam logic [2:0] c_ST_READY  = ST_READY;
    localparam logic [2:0] c_ST_READ   = ST_READ;
    localparam logic [2:0] c_ST_WACK   = ST_WACK;

    logic [2:0]        r_state;
    logic [7:0]        r_din;
    logic              r_wait;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;

    // Request captured during SETTLE, replayed once the RAM port is ours.
    logic              r_pend;
    logic              r_pend_wr;
    logic              r_pend_oor;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_data;

    logic              w_sel;
    logic              w_live_req;
    logic              w_live_oor;
    logic              w_req_valid;
    logic              w_req_wr;
    logic              w_req_oor;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_data;
    logic              w_cnt_load;
    logic [CNT_W-1:0]  w_cnt_val;
    logic              w_cnt_done;
    logic [7:0]        w_rd_byte;
    logic              w_unused;

    assign w_sel      = (ioctl_upload | ioctl_download) && (ioctl_index == 16'(NV_INDEX));
    assign w_live_req = w_sel & (ioctl_rd | ioctl_wr);
    assign w_live_oor = |(ioctl_addr >> ADDR_W);

    assign w_req_valid = r_pend | w_live_req;
    assign w_req_wr    = r_pend ? r_pend_wr   : ioctl_wr;
    assign w_req_oor   = r_pend ? r_pend_oor  : w_live_oor;
    assign w_req_addr  = r_pend ? r_pend_addr : ioctl_addr[ADDR_W-1:0];
    assign w_req_data  = r_pend ? r_pend_data : ioctl_dout[DATA_W-1:0];

    // One counter serves both the settle delay and the read latency.
    assign w_cnt_load = ((r_state == c_ST_IDLE) && w_sel) ||
                        ((r_state == c_ST_READY) && w_req_valid && !w_req_wr && !w_req_oor);
    assign w_cnt_val  = (r_state == c_ST_IDLE) ? CNT_W'(PAUSE_CYCLES) : CNT_W'(RD_LATENCY);

    nvram_settle_cnt #(
        .WIDTH    (CNT_W)
    ) u_cnt (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .done     (w_cnt_done)
    );

    generate
        if (DATA_W < 8) begin : g_pad
            assign w_rd_byte = {c_PAD_BYTE[7:DATA_W], nv_rdata};
        end else begin : g_full
            assign w_rd_byte = nv_rdata[7:0];
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_din       <= 8'h00;
            r_wait      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_wr   <= 1'b0;
            r_pend_oor  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_sel) begin
                        r_state <= c_ST_SETTLE;
                    end
                end
                c_ST_SETTLE: begin
                    if (!r_pend && w_live_req) begin
                        r_pend      <= 1'b1;
                        r_pend_wr   <= ioctl_wr;
                        r_pend_oor  <= w_live_oor;
                        r_pend_addr <= ioctl_addr[ADDR_W-1:0];
                        r_pend_data <= ioctl_dout[DATA_W-1:0];
                        r_wait      <= 1'b1;
                    end
                    if (w_cnt_done) begin
                        r_state <= c_ST_READY;
                    end
                end
                c_ST_READY: begin
                    if (w_req_valid) begin
                        r_pend <= 1'b0;
                        if (w_req_wr) begin
                            r_wait  <= 1'b1;
                            r_state <= c_ST_WACK;
                            if (!w_req_oor) begin
                                r_addr  <= w_req_addr;
                                r_wdata <= w_req_data;
                                r_we    <= 1'b1;
                            end
                        end else if (w_req_oor) begin
                            r_din  <= c_PAD_BYTE;
                            r_wait <= 1'b0;
                        end else begin
                            r_addr  <= w_req_addr;
                            r_wait  <= 1'b1;
                            r_state <= c_ST_READ;
                        end
                    end else if (!w_sel) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_READ: begin
                    if (w_cnt_done) begin
                        r_din   <= w_rd_byte;
                        r_wait  <= 1'b0;
                        r_state <= c_ST_READY;
                    end
                end
                c_ST_WACK: begin
                    r_wait  <= 1'b0;
                    r_state <= c_ST_READY;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ioctl_din  = r_din;
    assign ioctl_wait = r_wait;
    assign nv_addr    = r_addr;
    assign nv_wdata   = r_wdata;
    assign nv_we      = r_we;
    // Gated by reset so the CPU is released the moment reset asserts.
    assign cpu_pause  = !reset && (w_sel || (r_state != c_ST_IDLE));

    assign w_unused = ^{ioctl_dout, game_nv_we};

`ifdef NVRAM_DIRTY_EN
    logic r_dirty;
    logic r_dl_q;
    logic w_dl_sel;
    logic w_dirty_set;
    logic w_dirty_clr;

    assign w_dl_sel    = ioctl_download && (ioctl_index == 16'(NV_INDEX));
    assign w_dirty_set = game_nv_we && !cpu_pause;
    assign w_dirty_clr = (r_dl_q && !w_dl_sel) ||
                         ((r_state == c_ST_READY) && w_req_valid && !w_req_wr &&
                          !w_req_oor && (w_req_addr == '1) && ioctl_upload);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dirty <= 1'b0;
            r_dl_q  <= 1'b0;
        end else begin
            r_dl_q <= w_dl_sel;
            if (w_dirty_set) begin
                r_dirty <= 1'b1;
            end else if (w_dirty_clr) begin
                r_dirty <= 1'b0;
            end
        end
    end

    assign nv_dirty = r_dirty;
`else
    assign nv_dirty = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nvram_upload_ctrl.sv
// ============================================================================
// Module  : tb_nvram_upload_ctrl
// Brief   : Directed self-checking bench for nvram_upload_ctrl with a
//           two-cycle-latency CMOS model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nvram_upload_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic        ioctl_download;
    logic [15:0] ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        cpu_pause;
    logic [9:0]  nv_addr;
    logic [3:0]  nv_rdata;
    logic [3:0]  nv_wdata;
    logic        nv_we;
    logic        game_nv_we;
    logic        nv_dirty;

    logic [3:0]  mem [0:1023];
    logic [3:0]  rd_pipe;
    int          we_count;
    int          total;
    int          bad;
    int          we_before;
    logic        hold_ok;
    logic        exp_dirty_set;

    always #5 clk_sys = ~clk_sys;

    nvram_upload_ctrl dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_upload   (ioctl_upload),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_rd       (ioctl_rd),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .cpu_pause      (cpu_pause),
        .nv_addr        (nv_addr),
        .nv_rdata       (nv_rdata),
        .nv_wdata       (nv_wdata),
        .nv_we          (nv_we),
        .game_nv_we     (game_nv_we),
        .nv_dirty       (nv_dirty)
    );

    // CMOS model: data appears two cycles after the address is presented.
    always @(posedge clk_sys) begin
        rd_pipe  <= mem[nv_addr];
        nv_rdata <= rd_pipe;
        if (nv_we) begin
            mem[nv_addr] <= nv_wdata;
            we_count     <= we_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    initial begin
        total = 0;
        bad = 0;
        we_count = 0;
        rd_pipe = 4'h0;
        nv_rdata = 4'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 4'h0;
        mem[10'h005] = 4'hA;
        mem[10'h3FF] = 4'h2;
`ifdef NVRAM_DIRTY_EN
        exp_dirty_set = 1'b1;
`else
        exp_dirty_set = 1'b0;
`endif

        reset = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index = 16'd0;
        ioctl_addr = 25'd0;
        ioctl_rd = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_dout = 8'h00;
        game_nv_we = 1'b0;
        tick(3);
        chk("rst_din", 32'(ioctl_din), 32'h00);
        chk("rst_wait", 32'(ioctl_wait), 32'h0);
        chk("rst_pause", 32'(cpu_pause), 32'h0);
        chk("rst_addr", 32'(nv_addr), 32'h000);
        chk("rst_wdata", 32'(nv_wdata), 32'h0);
        chk("rst_we", 32'(nv_we), 32'h0);
        chk("rst_dirty", 32'(nv_dirty), 32'h0);
        reset = 1'b0;
        tick(1);

        // Game writes CMOS while running
        game_nv_we = 1'b1;
        tick(1);
        game_nv_we = 1'b0;
        chk("dirty_set", 32'(nv_dirty), 32'(exp_dirty_set));

        // Upload session, plain read of 0x005
        ioctl_index = 16'd4;
        ioctl_upload = 1'b1;
        #1;
        chk("pause_on_sel", 32'(cpu_pause), 32'h1);
        tick(20);
        ioctl_addr = 25'h005;
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        chk("up_wait_c1", 32'(ioctl_wait), 32'h1);
        chk("up_addr", 32'(nv_addr), 32'h005);
        tick(1);
        chk("up_wait_c2", 32'(ioctl_wait), 32'h1);
        tick(1);
        chk("up_wait_c3", 32'(ioctl_wait), 32'h1);
        chk("up_din_early", 32'(ioctl_din), 32'h00);
        tick(1);
        chk("up_din", 32'(ioctl_din), 32'hFA);
        chk("up_wait_fall", 32'(ioctl_wait), 32'h0);

        // Out-of-range read
        we_before = we_count;
        ioctl_addr = 25'h400;
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        chk("oor_din", 32'(ioctl_din), 32'hFF);
        chk("oor_wait", 32'(ioctl_wait), 32'h0);
        chk("oor_addr", 32'(nv_addr), 32'h005);
        chk("oor_we", 32'(we_count - we_before), 32'h0);

        // Last address read clears dirty
        ioctl_addr = 25'h3FF;
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        tick(3);
        chk("last_din", 32'(ioctl_din), 32'hF2);
        chk("dirty_clr", 32'(nv_dirty), 32'h0);

        ioctl_upload = 1'b0;
        #1;
        chk("pause_hold", 32'(cpu_pause), 32'h1);
        tick(1);
        chk("pause_release", 32'(cpu_pause), 32'h0);

        // Restore session
        ioctl_download = 1'b1;
        tick(20);
        we_before = we_count;
        ioctl_addr = 25'h3FF;
        ioctl_dout = 8'h37;
        ioctl_wr = 1'b1;
        tick(1);
        ioctl_wr = 1'b0;
        chk("wr_we", 32'(nv_we), 32'h1);
        chk("wr_addr", 32'(nv_addr), 32'h3FF);
        chk("wr_wdata", 32'(nv_wdata), 32'h7);
        chk("wr_wait", 32'(ioctl_wait), 32'h1);
        tick(1);
        chk("wr_we_end", 32'(nv_we), 32'h0);
        chk("wr_wait_end", 32'(ioctl_wait), 32'h0);
        chk("wr_pulses", 32'(we_count - we_before), 32'h1);
        chk("wr_mem", 32'(mem[10'h3FF]), 32'h7);

        we_before = we_count;
        ioctl_addr = 25'h500;
        ioctl_wr = 1'b1;
        tick(1);
        ioctl_wr = 1'b0;
        chk("oorw_we", 32'(nv_we), 32'h0);
        chk("oorw_wait", 32'(ioctl_wait), 32'h1);
        tick(1);
        chk("oorw_wait_end", 32'(ioctl_wait), 32'h0);
        chk("oorw_pulses", 32'(we_count - we_before), 32'h0);

        // Simultaneous rd and wr: write wins
        ioctl_addr = 25'h010;
        ioctl_dout = 8'h5C;
        ioctl_rd = 1'b1;
        ioctl_wr = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        ioctl_wr = 1'b0;
        chk("rw_we", 32'(nv_we), 32'h1);
        chk("rw_wdata", 32'(nv_wdata), 32'hC);
        tick(3);
        chk("rw_wait", 32'(ioctl_wait), 32'h0);
        chk("rw_din_kept", 32'(ioctl_din), 32'hF2);
        ioctl_download = 1'b0;
        tick(2);

        // Early request during SETTLE
        ioctl_upload = 1'b1;
        tick(2);
        ioctl_addr = 25'h3FF;
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        chk("early_wait", 32'(ioctl_wait), 32'h1);
        hold_ok = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick(1);
            if (ioctl_wait !== 1'b1 || ioctl_din !== 8'hF2) hold_ok = 1'b0;
        end
        chk("early_hold", 32'(hold_ok), 32'h1);
        tick(1);
        chk("early_din", 32'(ioctl_din), 32'hF7);
        chk("early_wait_fall", 32'(ioctl_wait), 32'h0);

        // Reset in the middle of a READ
        ioctl_addr = 25'h005;
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        chk("pre_rst_wait", 32'(ioctl_wait), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wait", 32'(ioctl_wait), 32'h0);
        chk("mid_rst_pause", 32'(cpu_pause), 32'h0);
        chk("mid_rst_we", 32'(nv_we), 32'h0);
        chk("mid_rst_din", 32'(ioctl_din), 32'h00);
        chk("mid_rst_addr", 32'(nv_addr), 32'h000);
        tick(1);
        ioctl_upload = 1'b0;
        reset = 1'b0;
        tick(2);

        // Non-matching index
        we_before = we_count;
        ioctl_index = 16'd0;
        ioctl_download = 1'b1;
        #1;
        chk("wi_pause", 32'(cpu_pause), 32'h0);
        tick(20);
        ioctl_addr = 25'h005;
        ioctl_dout = 8'h33;
        ioctl_wr = 1'b1;
        tick(1);
        ioctl_wr = 1'b0;
        chk("wi_we", 32'(nv_we), 32'h0);
        chk("wi_wait", 32'(ioctl_wait), 32'h0);
        ioctl_rd = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        tick(3);
        chk("wi_din", 32'(ioctl_din), 32'h00);
        chk("wi_pulses", 32'(we_count - we_before), 32'h0);
        chk("wi_pause_end", 32'(cpu_pause), 32'h0);
        ioctl_download = 1'b0;
        tick(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nvram_upload_ctrl.md
# nvram_upload_ctrl

Services the HPS ioctl file channel for the game's battery-backed CMOS RAM. It answers `ioctl_rd` upload requests by reading CMOS and returning bytes, so high scores and settings can be saved to SD. It also accepts `ioctl_wr` restore writes on the same index. It sits in the emu top between `hps_io` and the CMOS port of the `williams2` core, and pauses the CPU while it owns the RAM port.

## Interface
Parameters:
- `ADDR_W`, 10: CMOS address width (1K locations).
- `DATA_W`, 4: CMOS data width (1–8).
- `NV_INDEX`, 4: ioctl_index value that selects this block.
- `RD_LATENCY`, 2: CMOS read latency in clk_sys cycles (≥1).
- `PAUSE_CYCLES`, 16: settle time after `cpu_pause` rises, before the first RAM access (≥1).

Ports:
- `clk_sys` in 1: system clock (12 MHz).
- `reset` in 1: asynchronous, active-high.
- `ioctl_upload` in 1: HPS upload session active.
- `ioctl_download` in 1: HPS download session active.
- `ioctl_index` in 16: file index.
- `ioctl_addr` in 25: byte address, valid with rd/wr.
- `ioctl_rd` in 1: one-cycle read request.
- `ioctl_wr` in 1: one-cycle write strobe.
- `ioctl_dout` in 8: restore data.
- `ioctl_din` out 8: upload data.
- `ioctl_wait` out 1: stalls hps_io.
- `cpu_pause` out 1: halts the game CPU and frees the CMOS port.
- `nv_addr` out ADDR_W: CMOS address.
- `nv_rdata` in DATA_W: CMOS read data.
- `nv_wdata` out DATA_W: CMOS write data.
- `nv_we` out 1: CMOS write enable, one cycle.
- `game_nv_we` in 1: CPU CMOS write strobe (dirty tracking).
- `nv_dirty` out 1: CMOS modified since last save/restore.

## Operation
- `sel` = (`ioctl_upload` | `ioctl_download`) & (`ioctl_index` == `NV_INDEX`).
- `cpu_pause` = 1 while `sel`, and while the FSM is not IDLE.
- States:
  - **IDLE**: when `sel` rises, go to SETTLE and load the counter with `PAUSE_CYCLES`.
  - **SETTLE**: count down to 0, then go to READY. An rd/wr that arrives in SETTLE is latched (address, data, kind), `ioctl_wait` is raised, and the access is serviced on entry to READY.
  - **READY**:
    - On `ioctl_wr` (or latched wr): drive `nv_addr`/`nv_wdata` = `ioctl_dout[DATA_W-1:0]`, pulse `nv_we`, go to WACK.
    - On `ioctl_rd`: drive `nv_addr`, go to READ.
    - When `sel` falls: go to IDLE.
  - **READ**: wait `RD_LATENCY` cycles, then capture `ioctl_din` = {ones(8-DATA_W), `nv_rdata`}. Return to READY.
  - **WACK**: one cycle, then return to READY.
- Out-of-range address (`ioctl_addr` ≥ 2^ADDR_W):
  - Reads return 8'hFF with no RAM access, taking one cycle.
  - Writes are ignored, taking one cycle.
- rd and wr in the same cycle: wr wins and rd is dropped.
- `sel` dropping mid-access: the current access completes, then the FSM goes to IDLE. `cpu_pause` stays high until IDLE.
- Non-matching index: no response. `ioctl_wait` stays 0 and `ioctl_din` holds its value.

## Timing
- Reset values:
  - `ioctl_din`=0, `ioctl_wait`=0, `cpu_pause`=0.
  - `nv_addr`=0, `nv_wdata`=0, `nv_we`=0, `nv_dirty`=0.
- `ioctl_wait` rises in the cycle after the accepted rd/wr. It falls in the same cycle `ioctl_din` updates (read) or in the WACK cycle (write).
- Read latency from `ioctl_rd` to valid `ioctl_din`: `RD_LATENCY`+1 cycles in READY. Out-of-range reads take 1 cycle.
- First access after `sel` rises completes no earlier than `PAUSE_CYCLES`+`RD_LATENCY`+1 cycles.
- Reset mid-operation: all outputs return to reset values immediately and the FSM goes to IDLE. No partial `nv_we` pulse is generated.

## Configuration
- `NVRAM_DIRTY_EN` defined:
  - `nv_dirty` sets on `game_nv_we` while not paused.
  - It clears when an upload reads address 2^ADDR_W−1, or when a download session ends.
  - If set and clear occur in the same cycle, set wins.
- `NVRAM_DIRTY_EN` undefined: `nv_dirty` is tied to 0 and `game_nv_we` is ignored.

## Structure
- `nvram_pkg` holds:
  - the FSM state enum (IDLE, SETTLE, READY, READ, WACK);
  - the default `NV_INDEX`;
  - the pad-byte constant 8'hFF.
- One sub-module, `nvram_settle_cnt`: a loadable down-counter with a `done` flag, used for both SETTLE and READ latency.

## Test plan
- **Upload:**
  - Stimulus: preload CMOS[0x005]=4'hA, index 4, `ioctl_upload`=1, wait settle, `ioctl_rd` at addr 5.
  - Required: `ioctl_din`=8'hFA exactly 3 cycles later, `ioctl_wait` high for those cycles.
- **Out of range:**
  - Stimulus: rd at addr 0x400.
  - Required: `ioctl_din`=8'hFF after 1 cycle, no `nv_we` and no `nv_addr` change.
- **Restore:**
  - Stimulus: download index 4, wr addr 0x3FF data 8'h37.
  - Required: one `nv_we` pulse with `nv_addr`=0x3FF and `nv_wdata`=4'h7.
- **Early request:**
  - Stimulus: rd issued 2 cycles after `ioctl_upload` rises.
  - Required: `ioctl_wait` held high through SETTLE, correct data returned after 16+3 cycles.
- **Wrong index / reset:**
  - Stimulus 1: index 0 download.
  - Required: `cpu_pause`=0 and no `nv_we`.
  - Stimulus 2: assert `reset` during READ.
  - Required: `ioctl_wait`, `cpu_pause`, `nv_we` all 0 immediately.
- **Dirty tracking (`NVRAM_DIRTY_EN`):**
  - Stimulus: `game_nv_we` pulse, then upload through addr 0x3FF.
  - Required: `nv_dirty` 1 after the pulse, and 0 after the last read.
